// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the sequential multi-channel FIR.
//   fir_state_e : frame sequencer states
//   acc_w()     : accumulator width that holds a full-length dot product
//                 without wrap (sample + coefficient + log2(taps) bits)
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      FLUSH = 2'd2
   } fir_state_e;

   function automatic int acc_w(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// fir_coef_rom -- coefficient store with one-cycle registered read.
//   clk    : read clock
//   i_addr : tap index, valid range 0..TAPS-1
//   o_coef : c[i_addr] of the previous cycle (Q1.(COEF_W-1))
// The array is filled externally (e.g. hierarchical preload).
module fir_coef_rom #(
   parameter int    COEF_W    = 16,
   parameter int    TAPS      = 1021,
   parameter string COEF_FILE = "coef.hex",
   localparam int   AW        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic              clk,
   input  logic [AW-1:0]     i_addr,
   output logic [COEF_W-1:0] o_coef
);

   logic [COEF_W-1:0] r_mem [TAPS];

   always_ff @(posedge clk) o_coef <= r_mem[i_addr];

endmodule

// File: rtl/fir_seq_param.sv
// fir_seq_param -- sequential FIR: one sample per cycle per channel is
// multiplied by c[k] and summed; the frame result is emitted when
// sequencing drops.
//   clk, rst_n  : clock, async active-low reset
//   sequencing  : high while frame samples are presented (one per cycle)
//   smpl_in     : NUM_CH packed signed samples, channel 0 in LSBs
//   smpl_out    : registered saturated results, held between frames
//   out_vld     : one-cycle pulse when smpl_out updates
//   sat         : with out_vld, any channel clipped
//   tap_ovr     : one-cycle pulse, registered, after the sample k = TAPS
//   seq_drop    : one-cycle pulse, registered, after a sample seen in FLUSH
module fir_seq_param
   import fir_pkg::*;
#(
   parameter int    NUM_CH    = 2,
   parameter int    DATA_W    = 16,
   parameter int    COEF_W    = 16,
   parameter int    TAPS      = 1021,
   parameter string COEF_FILE = "coef.hex"
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sequencing,
   input  logic [NUM_CH*DATA_W-1:0] smpl_in,
   output logic [NUM_CH*DATA_W-1:0] smpl_out,
   output logic                     out_vld,
   output logic                     sat,
   output logic                     tap_ovr,
   output logic                     seq_drop
);

   localparam int            ACC_W = acc_w(DATA_W, COEF_W, TAPS);
   localparam int            AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [AW-1:0] LAST  = AW'(TAPS - 1);

   fir_state_e r_state, w_state_nxt;
   logic [AW-1:0]              r_addr;
   logic                       r_ovr;      // all TAPS samples taken, addr parked
   logic                       r_ovr_seen; // tap_ovr already reported this frame
   logic                       r_pvld;     // product stage holds a sample to add
   logic [NUM_CH*DATA_W-1:0]   r_x;
   logic                       r_vld, r_sat, r_tap, r_drop;
   logic signed [COEF_W-1:0]   w_coef;
   logic [NUM_CH-1:0]          w_clip;
   logic                       w_take, w_done, w_drop, w_ovr_hit;

   fir_coef_rom #(.COEF_W(COEF_W), .TAPS(TAPS), .COEF_FILE(COEF_FILE)) u_rom (
      .clk    (clk),
      .i_addr (r_addr),
      .o_coef (w_coef)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // w_done: last product is in flight this cycle; it is folded straight
   // into the output load so the result appears the cycle after.
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_done      = 1'b0;
      w_drop      = 1'b0;
      w_ovr_hit   = 1'b0;
      case (r_state)
         IDLE: if (sequencing) begin
            w_take      = 1'b1;
            w_state_nxt = CONV;
         end
         CONV: if (sequencing) begin
            w_take    = ~r_ovr;
            w_ovr_hit = r_ovr & ~r_ovr_seen;
         end else begin
            w_done      = 1'b1;
            w_state_nxt = FLUSH;
         end
         FLUSH: if (sequencing) begin
            w_drop      = 1'b1;
            w_state_nxt = CONV;
         end else begin
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr     <= '0;
         r_ovr      <= 1'b0;
         r_ovr_seen <= 1'b0;
         r_pvld     <= 1'b0;
         r_x        <= '0;
         r_vld      <= 1'b0;
         r_sat      <= 1'b0;
         r_tap      <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_x    <= smpl_in;
         r_pvld <= w_take;
         r_vld  <= w_done;
         r_sat  <= w_done & (|w_clip);
         r_tap  <= w_ovr_hit;
         r_drop <= w_drop;
         if (w_done) begin
            r_addr     <= '0;
            r_ovr      <= 1'b0;
            r_ovr_seen <= 1'b0;
         end else begin
            if (w_take) begin
               if (r_addr == LAST) r_ovr  <= 1'b1;
               else                r_addr <= r_addr + 1'b1;
            end
            if (w_ovr_hit) r_ovr_seen <= 1'b1;
         end
      end
   end

   assign out_vld  = r_vld;
   assign sat      = r_sat;
   assign tap_ovr  = r_tap;
   assign seq_drop = r_drop;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic signed [DATA_W-1:0]        w_x;
      logic signed [DATA_W+COEF_W-1:0] w_prod;
      logic signed [ACC_W-1:0]         w_sum, w_shift;
      logic [ACC_W-DATA_W:0]           w_hi;
      logic                            w_pos, w_neg;
      logic [DATA_W-1:0]               w_res;
      logic signed [ACC_W-1:0]         r_acc;
      logic [DATA_W-1:0]               r_out;

      assign w_x     = r_x[g*DATA_W +: DATA_W];
      assign w_prod  = w_x * w_coef;
      assign w_sum   = r_pvld ? r_acc + ACC_W'(w_prod) : r_acc;
      assign w_shift = w_sum >>> (COEF_W - 1);
      // In range only if every bit from the output sign bit upward agrees.
      assign w_hi    = w_shift[ACC_W-1:DATA_W-1];
      assign w_pos   = ~w_shift[ACC_W-1] & (|w_hi);
      assign w_neg   =  w_shift[ACC_W-1] & ~(&w_hi);
      assign w_res   = w_pos ? {1'b0, {(DATA_W-1){1'b1}}} :
                       w_neg ? {1'b1, {(DATA_W-1){1'b0}}} : w_shift[DATA_W-1:0];
      assign w_clip[g] = w_pos | w_neg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_acc <= '0;
            r_out <= '0;
         end else begin
            r_acc <= w_done ? '0 : w_sum;
            if (w_done) r_out <= w_res;
         end
      end

      assign smpl_out[g*DATA_W +: DATA_W] = r_out;
   end

endmodule

// File: tb/tb_fir_seq_param.sv
// tb_fir_seq_param -- two DUT builds (TAPS=8 and TAPS=4) share one stimulus
// stream; expected outputs come from a frame-level dot-product model.
`timescale 1ns/1ps
module tb_fir_seq_param;

   localparam int MAXC = 160;

   logic        clk = 1'b0;
   logic        rst_n, sequencing;
   logic [31:0] smpl_in;
   logic [31:0] o8_out, o4_out;
   logic        o8_vld, o8_sat, o8_tap, o8_drp;
   logic        o4_vld, o4_sat, o4_tap, o4_drp;

   int          n_vec = 0, n_err = 0;
   int          cf [8];
   bit          m_seq [$];
   logic [31:0] m_smp [$];
   logic [31:0] hold  [2];
   logic [31:0] e_out [2][MAXC];
   bit          e_vld [2][MAXC];
   bit          e_sat [2][MAXC];
   bit          e_tap [2][MAXC];
   bit          e_drp [2][MAXC];

   always #5 clk = ~clk;

   fir_seq_param #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .TAPS(8), .COEF_FILE("")) dut8 (
      .clk(clk), .rst_n(rst_n), .sequencing(sequencing), .smpl_in(smpl_in),
      .smpl_out(o8_out), .out_vld(o8_vld), .sat(o8_sat), .tap_ovr(o8_tap), .seq_drop(o8_drp));

   fir_seq_param #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .TAPS(4), .COEF_FILE("")) dut4 (
      .clk(clk), .rst_n(rst_n), .sequencing(sequencing), .smpl_in(smpl_in),
      .smpl_out(o4_out), .out_vld(o4_vld), .sat(o4_sat), .tap_ovr(o4_tap), .seq_drop(o4_drp));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " dut8 out"}, o8_out, 32'h0);
      chk({nm, " dut8 flags"}, {28'h0, o8_vld, o8_sat, o8_tap, o8_drp}, 32'h0);
      chk({nm, " dut4 out"}, o4_out, 32'h0);
      chk({nm, " dut4 flags"}, {28'h0, o4_vld, o4_sat, o4_tap, o4_drp}, 32'h0);
   endtask

   // 0: all 0x4000 (0.5), 1: all 0x7FFF, 2: random excluding -1.0
   task automatic load(input int mode);
      for (int i = 0; i < 8; i++) begin
         cf[i] = (mode == 0) ? 32'sh4000 : (mode == 1) ? 32'sh7FFF :
                 int'($urandom_range(0, 65534)) - 32767;
         dut8.u_rom.r_mem[i] = 16'(cf[i]);
         if (i < 4) dut4.u_rom.r_mem[i] = 16'(cf[i]);
      end
   endtask

   task automatic push(input bit s, input logic [15:0] a, input logic [15:0] b);
      m_seq.push_back(s);
      m_smp.push_back({b, a});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 16'($urandom), 16'($urandom));
   endtask

   function automatic logic [16:0] finish_ch(input longint acc);
      longint q;
      q = acc >>> 15;
      if (q > 32767)  return {1'b1, 16'h7FFF};
      if (q < -32768) return {1'b1, 16'h8000};
      return {1'b0, 16'(q)};
   endfunction

   // Frame-level model. Index t = outputs seen just after the edge that
   // ends stimulus cycle t.
   task automatic model(input int d, input int taps);
      int          mode;   // 0 between frames, 1 collecting, 2 cycle after frame end
      int          n;
      longint      acc0, acc1;
      logic [16:0] r0, r1;
      mode = 0; n = 0; acc0 = 0; acc1 = 0;
      for (int t = 0; t < m_seq.size(); t++) begin
         e_vld[d][t] = 0; e_sat[d][t] = 0; e_tap[d][t] = 0; e_drp[d][t] = 0;
         if (mode == 1 && !m_seq[t]) begin
            r0 = finish_ch(acc0);
            r1 = finish_ch(acc1);
            hold[d]     = {r1[15:0], r0[15:0]};
            e_vld[d][t] = 1;
            e_sat[d][t] = r0[16] | r1[16];
            mode = 2;
         end else if (mode == 2) begin
            if (m_seq[t]) begin
               e_drp[d][t] = 1;
               mode = 1; n = 0; acc0 = 0; acc1 = 0;
            end else mode = 0;
         end else if (m_seq[t]) begin
            if (mode == 0) begin mode = 1; n = 0; acc0 = 0; acc1 = 0; end
            if (n < taps) begin
               acc0 += longint'($signed(m_smp[t][15:0]))  * longint'(cf[n]);
               acc1 += longint'($signed(m_smp[t][31:16])) * longint'(cf[n]);
            end else if (n == taps) e_tap[d][t] = 1;
            n++;
         end
         e_out[d][t] = hold[d];
      end
   endtask

   task automatic run(input string nm);
      model(0, 8);
      model(1, 4);
      for (int t = 0; t < m_seq.size(); t++) begin
         sequencing = m_seq[t];
         smpl_in    = m_smp[t];
         @(posedge clk); #1;
         chk($sformatf("%s t%0d dut8 out", nm, t), o8_out, e_out[0][t]);
         chk($sformatf("%s t%0d dut8 vld/sat/tap/drop", nm, t),
             {28'h0, o8_vld, o8_sat, o8_tap, o8_drp},
             {28'h0, e_vld[0][t], e_sat[0][t], e_tap[0][t], e_drp[0][t]});
         chk($sformatf("%s t%0d dut4 out", nm, t), o4_out, e_out[1][t]);
         chk($sformatf("%s t%0d dut4 vld/sat/tap/drop", nm, t),
             {28'h0, o4_vld, o4_sat, o4_tap, o4_drp},
             {28'h0, e_vld[1][t], e_sat[1][t], e_tap[1][t], e_drp[1][t]});
      end
      m_seq.delete();
      m_smp.delete();
      sequencing = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; sequencing = 1'b0; smpl_in = '0;
      hold[0] = '0; hold[1] = '0;
      #1 rst_n = 1'b0;
      load(0);
      #1 chk_zero("por");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // 4 x (0x1000 * 0.5) = 0x2000, and the negated channel
      load(0);
      idle(2);
      for (int i = 0; i < 4; i++) push(1'b1, 16'h1000, 16'hF000);
      idle(2);
      run("basic");
      chk("basic dut8 result", o8_out, 32'hE000_2000);
      chk("basic dut4 result", o4_out, 32'hE000_2000);

      // single-sample frame
      push(1'b1, 16'h4000, 16'h4000);
      idle(3);
      run("single");
      chk("single dut8 result", o8_out, 32'h2000_2000);

      // clipping both ways
      load(1);
      for (int i = 0; i < 8; i++) push(1'b1, 16'h7FFF, 16'h8000);
      idle(2);
      run("sat");
      chk("sat dut8 result", o8_out, 32'h8000_7FFF);
      chk("sat dut4 result", o4_out, 32'h8000_7FFF);

      // 6 samples: TAPS=4 stops at 4, TAPS=8 takes all 6
      load(0);
      for (int i = 0; i < 6; i++) push(1'b1, 16'h1000, 16'h1000);
      idle(2);
      run("ovr");
      chk("ovr dut4 result", o4_out, 32'h2000_2000);
      chk("ovr dut8 result", o8_out, 32'h3000_3000);

      // restart while flushing
      load(2);
      for (int i = 0; i < 5; i++) push(1'b1, 16'($urandom), 16'($urandom));
      push(1'b0, 16'h0, 16'h0);
      push(1'b1, 16'h7FFF, 16'h7FFF);
      for (int i = 0; i < 3; i++) push(1'b1, 16'($urandom), 16'($urandom));
      idle(2);
      run("b2b");

      // random frames, gaps and restarts
      load(2);
      for (int f = 0; f < 6; f++) begin
         int len;
         len = $urandom_range(1, 11);
         for (int i = 0; i < len; i++) push(1'b1, 16'($urandom), 16'($urandom));
         push(1'b0, 16'($urandom), 16'($urandom));
         if (f < 5 && $urandom_range(0, 2) == 0) push(1'b1, 16'($urandom), 16'($urandom));
         else idle($urandom_range(1, 3));
      end
      idle(1);
      run("rand");

      // reset in the middle of a frame
      load(2);
      for (int i = 0; i < 3; i++) begin
         sequencing = 1'b1;
         smpl_in    = $urandom;
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      sequencing = 1'b0;
      #1 chk_zero("mid_rst");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      hold[0] = '0; hold[1] = '0;
      idle(4);
      for (int i = 0; i < 6; i++) push(1'b1, 16'($urandom), 16'($urandom));
      idle(2);
      run("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
